// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage refill controller: FSM encoding and
// cache line geometry.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_e;

  localparam int LINE_W     = 128;
  localparam int LINE_OFF_W = 4;

endpackage

// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss/refill sequencer: stalls fetch on a miss, requests the
// line from instruction memory (re-issuing on timeout) and writes it to the cache.
module icache_refill_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = fetch_pkg::LINE_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              cache_hit,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_line,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              pc_stall,
  output logic              busy,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  retry_count,
  output logic [1:0]        dbg_state
);

  // Handshake: mem_req is a single-cycle pulse with mem_addr valid alongside it;
  // memory answers with mem_ready for one cycle carrying mem_line. A response is
  // only consumed in WAIT, so a late answer to a timed-out request is dropped.

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
  logic [LINE_W-1:0]  line_buf_q, line_buf_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   retry_cnt_q, retry_cnt_d;

  logic               miss_now;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^fetch_addr[LINE_OFF_W-1:0];
  assign miss_now         = fetch_req & ~cache_hit;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    line_buf_d  = line_buf_q;
    wait_cnt_d  = wait_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_now) begin
          miss_addr_d = {fetch_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
          miss_cnt_d  = miss_cnt_q + CNT_W'(1);
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // A response on the timeout cycle itself is still taken.
        if (mem_ready) begin
          line_buf_d = mem_line;
          state_d    = ST_FILL;
        end else if (wait_cnt_d == TIMEOUT_CNT) begin
          retry_cnt_d = retry_cnt_q + CNT_W'(1);
          state_d     = ST_REQ;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      miss_addr_q <= '0;
      line_buf_q  <= '0;
      wait_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      line_buf_q  <= line_buf_d;
      wait_cnt_q  <= wait_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  // The stall is combinational in IDLE so the missing fetch is held immediately.
  assign pc_stall    = (state_q != ST_IDLE) | miss_now;
  assign busy        = (state_q != ST_IDLE);
  assign mem_req     = (state_q == ST_REQ);
  assign fill_we     = (state_q == ST_FILL);
  assign mem_addr    = miss_addr_q;
  assign fill_addr   = miss_addr_q;
  assign fill_line   = line_buf_q;
  assign miss_count  = miss_cnt_q;
  assign retry_count = retry_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl; a second instance with 4-bit counters
// shares all inputs to exercise counter wrap.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fetch_req = 1'b0;
  logic [31:0]  fetch_addr = '0;
  logic         cache_hit = 1'b0;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_line = '0;

  logic         mem_req, fill_we, pc_stall, busy;
  logic [31:0]  mem_addr, fill_addr;
  logic [127:0] fill_line;
  logic [15:0]  miss_count, retry_count;
  logic [1:0]   dbg_state;

  logic         mem_req4, fill_we4, pc_stall4, busy4;
  logic [31:0]  mem_addr4, fill_addr4;
  logic [127:0] fill_line4;
  logic [3:0]   miss_count4, retry_count4;
  logic [1:0]   dbg_state4;

  int n_checks = 0;
  int n_errors = 0;
  int req_seen, stall_seen, fill_seen;
  logic [127:0] exp_q[$];

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .cache_hit(cache_hit), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_line(mem_line), .fill_we(fill_we),
    .fill_addr(fill_addr), .fill_line(fill_line), .pc_stall(pc_stall),
    .busy(busy), .miss_count(miss_count), .retry_count(retry_count),
    .dbg_state(dbg_state)
  );

  icache_refill_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .cache_hit(cache_hit), .mem_req(mem_req4), .mem_addr(mem_addr4),
    .mem_ready(mem_ready), .mem_line(mem_line), .fill_we(fill_we4),
    .fill_addr(fill_addr4), .fill_line(fill_line4), .pc_stall(pc_stall4),
    .busy(busy4), .miss_count(miss_count4), .retry_count(retry_count4),
    .dbg_state(dbg_state4)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every fill strobe must match the next expected line.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req)  req_seen++;
      if (pc_stall) stall_seen++;
      if (fill_we) begin
        fill_seen++;
        if (exp_q.size() == 0) check("fill_unexpected", 128'd1, 128'd0);
        else check("fill_line", fill_line, exp_q.pop_front());
      end
    end
  end

  task automatic clear_seen();
    req_seen   = 0;
    stall_seen = 0;
    fill_seen  = 0;
  endtask

  // Drives one miss; memory answers k cycles after the first REQ cycle.
  task automatic run_miss(input logic [31:0] addr, input logic [127:0] line, input int k);
    exp_q.push_back(line);
    @(posedge clk); #1;
    fetch_req = 1'b1; cache_hit = 1'b0; fetch_addr = addr;
    @(negedge clk);
    check("miss_stall", pc_stall, 1'b1);
    @(posedge clk); #1;
    cache_hit = 1'b1;
    @(negedge clk);
    check("req_addr", mem_addr, {addr[31:4], 4'b0});
    for (int c = 1; c <= k; c++) begin
      @(posedge clk); #1;
      mem_ready = (c == k);
      mem_line  = (c == k) ? line : 128'hDEAD;
    end
    @(posedge clk); #1;
    mem_ready = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    check("fill_we", fill_we, 1'b1);
    check("fill_addr", fill_addr, {addr[31:4], 4'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("release_stall", pc_stall, 1'b0);
    check("release_busy", busy, 1'b0);
  endtask

  initial begin
    clear_seen();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-WAIT
    @(posedge clk); #1;
    fetch_req = 1'b1; cache_hit = 1'b0; fetch_addr = 32'h0000_0124;
    @(posedge clk); #1;
    cache_hit = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_state", dbg_state, 2'd2);
    rst = 1'b1;
    #1;
    check("rst_state", dbg_state, 2'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_fill_we", fill_we, 1'b0);
    check("rst_stall", pc_stall, 1'b0);
    check("rst_miss_cnt", miss_count, 16'd0);
    check("rst_retry_cnt", retry_count, 16'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Hit path
    clear_seen();
    fetch_req = 1'b1; cache_hit = 1'b1; fetch_addr = 32'h0000_0200;
    repeat (10) @(posedge clk);
    #1 fetch_req = 1'b0;
    check("hit_stall", stall_seen, 0);
    check("hit_req", req_seen, 0);

    // Fast memory miss
    clear_seen();
    run_miss(32'h0000_0124, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 1);
    check("fast_stall_cycles", stall_seen, 4);
    check("fast_req_pulses", req_seen, 1);
    check("fast_fills", fill_seen, 1);
    check("fast_miss_cnt", miss_count, 16'd1);

    // Timeout and re-issue, answer 3 cycles after the second request
    clear_seen();
    run_miss(32'h0000_3458, 128'h11112222_33334444_55556666_77778888, 19);
    check("to_stall_cycles", stall_seen, 22);
    check("to_req_pulses", req_seen, 2);
    check("to_fills", fill_seen, 1);
    check("to_retry_cnt", retry_count, 16'd1);
    check("to_miss_cnt", miss_count, 16'd2);

    // Answer on the exact timeout cycle
    clear_seen();
    run_miss(32'h0000_ABCF, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 15);
    check("edge_req_pulses", req_seen, 1);
    check("edge_retry_cnt", retry_count, 16'd1);
    check("edge_stall_cycles", stall_seen, 18);

    // Stray mem_ready in IDLE
    clear_seen();
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_line = 128'hBAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("stray_fills", fill_seen, 0);
    check("stray_busy", busy, 1'b0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 12; i++)
      run_miss(32'h0000_1004 + 32'(i) * 32'h10, {4{32'hC0DE0000 + 32'(i)}}, 1);
    check("wrap_pre_cnt4", miss_count4, 4'd15);
    run_miss(32'h0000_2000, 128'h5A5A, 1);
    check("wrap_cnt4", miss_count4, 4'd0);
    check("wrap_cnt16", miss_count, 16'd16);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
